// File: rtl/id_stage_pipe_if.sv
// Bus bundle for the ID stage: IF/ID inputs, register-file ports, forwarding
// sources, the registered ID/EX latch outputs and the performance counters.
// The master side drives instructions and operands; the slave side is the
// decode stage itself.
interface id_stage_pipe_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_N  = 2
);
    logic                     in_valid_i;
    logic [DATA_W-1:0]        pc_i;
    logic [31:0]              inst_i;
    logic                     stall_i;
    logic                     flush_i;
    logic [DATA_W-1:0]        reg1_data_i;
    logic [DATA_W-1:0]        reg2_data_i;
    logic [FWD_N-1:0]         fwd_wreg_i;
    logic [FWD_N*REG_AW-1:0]  fwd_waddr_i;
    logic [FWD_N*DATA_W-1:0]  fwd_wdata_i;

    logic                     reg1_read_o;
    logic                     reg2_read_o;
    logic [REG_AW-1:0]        reg1_addr_o;
    logic [REG_AW-1:0]        reg2_addr_o;
    logic                     stall_req_o;
    logic                     ex_valid_o;
    logic [DATA_W-1:0]        ex_pc_o;
    logic [2:0]               ex_alusel_o;
    logic [7:0]               ex_aluop_o;
    logic [DATA_W-1:0]        ex_reg1_o;
    logic [DATA_W-1:0]        ex_reg2_o;
    logic [REG_AW-1:0]        ex_waddr_o;
    logic                     ex_wreg_o;
    logic                     ex_inv_o;
    logic [31:0]              perf_stall_cnt_o;
    logic [31:0]              perf_inv_cnt_o;

    modport master (
        output in_valid_i, pc_i, inst_i, stall_i, flush_i,
               reg1_data_i, reg2_data_i, fwd_wreg_i, fwd_waddr_i, fwd_wdata_i,
        input  reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stall_req_o,
               ex_valid_o, ex_pc_o, ex_alusel_o, ex_aluop_o, ex_reg1_o,
               ex_reg2_o, ex_waddr_o, ex_wreg_o, ex_inv_o,
               perf_stall_cnt_o, perf_inv_cnt_o
    );

    modport slave (
        input  in_valid_i, pc_i, inst_i, stall_i, flush_i,
               reg1_data_i, reg2_data_i, fwd_wreg_i, fwd_waddr_i, fwd_wdata_i,
        output reg1_read_o, reg2_read_o, reg1_addr_o, reg2_addr_o, stall_req_o,
               ex_valid_o, ex_pc_o, ex_alusel_o, ex_aluop_o, ex_reg1_o,
               ex_reg2_o, ex_waddr_o, ex_wreg_o, ex_inv_o,
               perf_stall_cnt_o, perf_inv_cnt_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// Instruction decode stage for the MIPS-subset pipeline: decodes one word per
// cycle, reads operands with multi-source forwarding (index 0 youngest),
// detects load-use hazards and owns the ID/EX latch.
// Optional feature macro: ID_PERF_CNT_EN enables the stall / invalid counters;
// without it both counter outputs are tied to zero.
module id_stage_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int FWD_N  = 2
) (
    input  logic          clk,
    input  logic          rst,
    id_stage_pipe_if.slave bus
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_ADDIU   = 6'b001001;
    localparam logic [5:0] OP_LW      = 6'b100011;

    localparam logic [2:0] SEL_NOP   = 3'b000;
    localparam logic [2:0] SEL_LOGIC = 3'b001;
    localparam logic [2:0] SEL_ARITH = 3'b100;
    localparam logic [2:0] SEL_LOAD  = 3'b111;

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] pc;
        logic [2:0]        alusel;
        logic [7:0]        aluop;
        logic [DATA_W-1:0] reg1;
        logic [DATA_W-1:0] reg2;
        logic [REG_AW-1:0] waddr;
        logic              wreg;
        logic              inv;
    } ex_t;

    logic [5:0]        op, func;
    logic [4:0]        rs, rt, rd;
    logic [15:0]       imm;
    logic              dec_r1_read, dec_r2_read;
    logic [DATA_W-1:0] dec_imm;
    logic [REG_AW-1:0] dec_waddr;
    logic              dec_wreg, dec_inv;
    logic [2:0]        dec_alusel;
    logic [7:0]        dec_aluop;
    logic [DATA_W-1:0] opnd1, opnd2;
    logic              stall_req;
    ex_t               ex_q, ex_d;

    assign op   = bus.inst_i[31:26];
    assign rs   = bus.inst_i[25:21];
    assign rt   = bus.inst_i[20:16];
    assign rd   = bus.inst_i[15:11];
    assign imm  = bus.inst_i[15:0];
    assign func = bus.inst_i[5:0];

    // Instruction decode: read enables, immediate, destination and ALU controls.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch.
        dec_r1_read = 1'b0;
        dec_r2_read = 1'b0;
        dec_imm     = '0;
        dec_waddr   = '0;
        dec_wreg    = 1'b0;
        dec_alusel  = SEL_NOP;
        dec_aluop   = 8'h00;
        dec_inv     = 1'b1;
        case (op)
            OP_ORI, OP_ANDI, OP_XORI: begin
                dec_r1_read = 1'b1;
                dec_imm     = DATA_W'(imm);
                dec_waddr   = REG_AW'(rt);
                dec_wreg    = 1'b1;
                dec_alusel  = SEL_LOGIC;
                dec_aluop   = (op == OP_ORI)  ? 8'h25 :
                              (op == OP_ANDI) ? 8'h24 : 8'h26;
                dec_inv     = 1'b0;
            end
            OP_LUI: begin
                dec_imm    = DATA_W'({imm, 16'h0000});
                dec_waddr  = REG_AW'(rt);
                dec_wreg   = 1'b1;
                dec_alusel = SEL_LOGIC;
                dec_aluop  = 8'h25;
                dec_inv    = 1'b0;
            end
            OP_ADDIU, OP_LW: begin
                dec_r1_read = 1'b1;
                dec_imm     = {{(DATA_W-16){imm[15]}}, imm};
                dec_waddr   = REG_AW'(rt);
                dec_wreg    = 1'b1;
                dec_alusel  = (op == OP_LW) ? SEL_LOAD : SEL_ARITH;
                dec_aluop   = (op == OP_LW) ? 8'hE3 : 8'h21;
                dec_inv     = 1'b0;
            end
            OP_SPECIAL: begin
                case (func)
                    6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23: begin
                        dec_r1_read = 1'b1;
                        dec_r2_read = 1'b1;
                        dec_waddr   = REG_AW'(rd);
                        dec_wreg    = 1'b1;
                        dec_alusel  = (func == 6'h21 || func == 6'h23) ? SEL_ARITH : SEL_LOGIC;
                        dec_aluop   = {2'b00, func};
                        dec_inv     = 1'b0;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.reg1_read_o = dec_r1_read;
    assign bus.reg2_read_o = dec_r2_read;
    assign bus.reg1_addr_o = dec_r1_read ? REG_AW'(rs) : '0;
    assign bus.reg2_addr_o = dec_r2_read ? REG_AW'(rt) : '0;

    // Operand resolution: immediate/zero when not read, $0 reads zero,
    // otherwise the youngest matching forwarding source beats the register file.
    function automatic logic [DATA_W-1:0] resolve(
        input logic                    rd_en,
        input logic [REG_AW-1:0]       addr,
        input logic [DATA_W-1:0]       rf_data,
        input logic [DATA_W-1:0]       alt,
        input logic [FWD_N-1:0]        fw_we,
        input logic [FWD_N*REG_AW-1:0] fw_addr,
        input logic [FWD_N*DATA_W-1:0] fw_data
    );
        logic [DATA_W-1:0] res;
        if (!rd_en) begin
            res = alt;
        end else if (addr == '0) begin
            res = '0;
        end else begin
            res = rf_data;
            // Walk oldest to youngest so the lowest matching index wins.
            for (int k = FWD_N - 1; k >= 0; k--) begin
                if (fw_we[k] && fw_addr[k*REG_AW +: REG_AW] == addr)
                    res = fw_data[k*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    // Operand mux for both read ports.
    always_comb begin
        opnd1 = resolve(dec_r1_read, bus.reg1_addr_o, bus.reg1_data_i, '0,
                        bus.fwd_wreg_i, bus.fwd_waddr_i, bus.fwd_wdata_i);
        opnd2 = resolve(dec_r2_read, bus.reg2_addr_o, bus.reg2_data_i, dec_imm,
                        bus.fwd_wreg_i, bus.fwd_waddr_i, bus.fwd_wdata_i);
    end

    // Load-use hazard: a load in ID/EX writing a register this instruction reads.
    assign stall_req = !rst && bus.in_valid_i && ex_q.valid && ex_q.alusel == SEL_LOAD &&
                       ex_q.wreg && ex_q.waddr != '0 &&
                       ((dec_r1_read && bus.reg1_addr_o == ex_q.waddr) ||
                        (dec_r2_read && bus.reg2_addr_o == ex_q.waddr));
    assign bus.stall_req_o = stall_req;

    // Next latch contents when a real instruction is accepted.
    always_comb begin
        ex_d.valid  = 1'b1;
        ex_d.pc     = bus.pc_i;
        ex_d.alusel = dec_alusel;
        ex_d.aluop  = dec_aluop;
        ex_d.reg1   = opnd1;
        ex_d.reg2   = opnd2;
        ex_d.waddr  = dec_waddr;
        ex_d.wreg   = dec_wreg;
        ex_d.inv    = dec_inv;
    end

    // ID/EX latch: reset, flush, hold, hazard bubble, empty slot, then load.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst || bus.flush_i)
            ex_q <= '0;
        else if (bus.stall_i)
            ex_q <= ex_q;
        else if (stall_req || !bus.in_valid_i)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign bus.ex_valid_o  = ex_q.valid;
    assign bus.ex_pc_o     = ex_q.pc;
    assign bus.ex_alusel_o = ex_q.alusel;
    assign bus.ex_aluop_o  = ex_q.aluop;
    assign bus.ex_reg1_o   = ex_q.reg1;
    assign bus.ex_reg2_o   = ex_q.reg2;
    assign bus.ex_waddr_o  = ex_q.waddr;
    assign bus.ex_wreg_o   = ex_q.wreg;
    assign bus.ex_inv_o    = ex_q.inv;

`ifdef ID_PERF_CNT_EN
    logic [31:0] stall_cnt, inv_cnt;
    logic        load_inst;

    assign load_inst = !bus.flush_i && !bus.stall_i && !stall_req && bus.in_valid_i;

    // Free-running wrap-around counters of lost cycles and invalid instructions.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            inv_cnt   <= '0;
        end else begin
            if (stall_req && !bus.stall_i)
                stall_cnt <= stall_cnt + 32'd1;
            if (load_inst && dec_inv)
                inv_cnt <= inv_cnt + 32'd1;
        end
    end

    assign bus.perf_stall_cnt_o = stall_cnt;
    assign bus.perf_inv_cnt_o   = inv_cnt;
`else
    assign bus.perf_stall_cnt_o = '0;
    assign bus.perf_inv_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Self-checking bench for id_stage_pipe: directed instruction vectors with
// literal expectations, plus a per-cycle comparison against a behavioural model.
module tb_id_stage_pipe;
    localparam int DATA_W = 32;
    localparam int REG_AW = 5;
    localparam int FWD_N  = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    bit   started = 1'b0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) bus ();

    id_stage_pipe #(.DATA_W(DATA_W), .REG_AW(REG_AW), .FWD_N(FWD_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        r1en, r2en;
        logic [4:0]  r1a, r2a, waddr;
        logic [31:0] imm;
        logic        wreg, inv;
        logic [2:0]  sel;
        logic [7:0]  op;
    } mdec_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] r1, r2;
        logic [4:0]  waddr;
        logic        wreg, inv;
    } mex_t;

    mex_t        m_ex;
    logic [31:0] m_stall_cnt, m_inv_cnt;

    function automatic mdec_t mdecode(input logic [31:0] w);
        mdec_t d;
        d     = '0;
        d.inv = 1'b1;
        case (w[31:26])
            6'h0D, 6'h0C, 6'h0E, 6'h0F, 6'h09, 6'h23: begin
                d.inv   = 1'b0;
                d.wreg  = 1'b1;
                d.waddr = w[20:16];
                d.r1en  = (w[31:26] != 6'h0F);
                d.r1a   = w[25:21];
                if (w[31:26] == 6'h0F)      d.imm = {w[15:0], 16'h0};
                else if (w[31:26] == 6'h09 || w[31:26] == 6'h23)
                                            d.imm = {{16{w[15]}}, w[15:0]};
                else                        d.imm = {16'h0, w[15:0]};
                case (w[31:26])
                    6'h0D, 6'h0F: begin d.sel = 3'd1; d.op = 8'h25; end
                    6'h0C:        begin d.sel = 3'd1; d.op = 8'h24; end
                    6'h0E:        begin d.sel = 3'd1; d.op = 8'h26; end
                    6'h09:        begin d.sel = 3'd4; d.op = 8'h21; end
                    default:      begin d.sel = 3'd7; d.op = 8'hE3; end
                endcase
            end
            6'h00: begin
                if (w[5:0] inside {6'h24, 6'h25, 6'h26, 6'h27, 6'h21, 6'h23}) begin
                    d.inv   = 1'b0;
                    d.wreg  = 1'b1;
                    d.r1en  = 1'b1;
                    d.r2en  = 1'b1;
                    d.r1a   = w[25:21];
                    d.r2a   = w[20:16];
                    d.waddr = w[15:11];
                    d.op    = {2'b00, w[5:0]};
                    d.sel   = (w[5:0] inside {6'h21, 6'h23}) ? 3'd4 : 3'd1;
                end
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] moperand(input logic en, input logic [4:0] a,
                                             input logic [31:0] rf, input logic [31:0] alt);
        if (!en) return alt;
        if (a == 5'd0) return 32'd0;
        for (int k = 0; k < FWD_N; k++)
            if (bus.fwd_wreg_i[k] && bus.fwd_waddr_i[k*REG_AW +: REG_AW] == a)
                return bus.fwd_wdata_i[k*DATA_W +: DATA_W];
        return rf;
    endfunction

    function automatic logic mstall();
        mdec_t d;
        d = mdecode(bus.inst_i);
        if (rst || !bus.in_valid_i || !m_ex.valid) return 1'b0;
        if (m_ex.sel != 3'd7 || !m_ex.wreg || m_ex.waddr == 5'd0) return 1'b0;
        return (d.r1en && d.r1a == m_ex.waddr) || (d.r2en && d.r2a == m_ex.waddr);
    endfunction

    // Model update at each clock edge, from inputs and the model's own state.
    always @(posedge clk) begin
        mdec_t d;
        logic  hz;
        d  = mdecode(bus.inst_i);
        hz = mstall();
        if (rst) begin
            m_stall_cnt = 0;
            m_inv_cnt   = 0;
        end else begin
            if (hz && !bus.stall_i) m_stall_cnt++;
            if (!bus.flush_i && !bus.stall_i && !hz && bus.in_valid_i && d.inv) m_inv_cnt++;
        end
        if (rst || bus.flush_i)                 m_ex = '0;
        else if (bus.stall_i)                   m_ex = m_ex;
        else if (hz || !bus.in_valid_i)         m_ex = '0;
        else begin
            m_ex.valid = 1'b1;
            m_ex.pc    = bus.pc_i;
            m_ex.sel   = d.sel;
            m_ex.op    = d.op;
            m_ex.r1    = moperand(d.r1en, d.r1a, bus.reg1_data_i, 32'd0);
            m_ex.r2    = moperand(d.r2en, d.r2a, bus.reg2_data_i, d.imm);
            m_ex.waddr = d.waddr;
            m_ex.wreg  = d.wreg;
            m_ex.inv   = d.inv;
        end
        started = 1'b1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every falling edge, DUT against model.
    always @(negedge clk) begin
        mdec_t d;
        if (started) begin
            d = mdecode(bus.inst_i);
            check("m_valid",  64'(bus.ex_valid_o),  64'(m_ex.valid));
            check("m_pc",     64'(bus.ex_pc_o),     64'(m_ex.pc));
            check("m_alusel", 64'(bus.ex_alusel_o), 64'(m_ex.sel));
            check("m_aluop",  64'(bus.ex_aluop_o),  64'(m_ex.op));
            check("m_reg1",   64'(bus.ex_reg1_o),   64'(m_ex.r1));
            check("m_reg2",   64'(bus.ex_reg2_o),   64'(m_ex.r2));
            check("m_waddr",  64'(bus.ex_waddr_o),  64'(m_ex.waddr));
            check("m_wreg",   64'(bus.ex_wreg_o),   64'(m_ex.wreg));
            check("m_inv",    64'(bus.ex_inv_o),    64'(m_ex.inv));
            check("m_stall",  64'(bus.stall_req_o), 64'(mstall()));
            check("m_rd1",    64'(bus.reg1_read_o), 64'(d.r1en));
            check("m_rd2",    64'(bus.reg2_read_o), 64'(d.r2en));
            if (d.r1en) check("m_addr1", 64'(bus.reg1_addr_o), 64'(d.r1a));
            if (d.r2en) check("m_addr2", 64'(bus.reg2_addr_o), 64'(d.r2a));
`ifdef ID_PERF_CNT_EN
            check("m_pstall", 64'(bus.perf_stall_cnt_o), 64'(m_stall_cnt));
            check("m_pinv",   64'(bus.perf_inv_cnt_o),   64'(m_inv_cnt));
`else
            check("m_pstall", 64'(bus.perf_stall_cnt_o), 64'd0);
            check("m_pinv",   64'(bus.perf_inv_cnt_o),   64'd0);
`endif
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [31:0] w);
        bus.in_valid_i = 1'b1;
        bus.pc_i       = pc;
        bus.inst_i     = w;
    endtask

    task automatic fwd(input logic [1:0] we, input logic [4:0] a1, input logic [31:0] d1,
                       input logic [4:0] a0, input logic [31:0] d0);
        bus.fwd_wreg_i  = we;
        bus.fwd_waddr_i = {a1, a0};
        bus.fwd_wdata_i = {d1, d0};
    endtask

    initial begin
        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.pc_i        = '0;
        bus.inst_i      = '0;
        bus.stall_i     = 1'b0;
        bus.flush_i     = 1'b0;
        bus.reg1_data_i = 32'h99;
        bus.reg2_data_i = 32'h77;
        fwd(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        cyc(); cyc();
        check("rst_valid", 64'(bus.ex_valid_o), 64'd0);
        check("rst_stall", 64'(bus.stall_req_o), 64'd0);
        rst = 1'b0;

        // ORI $1,$0,0x1234
        instr(32'h100, 32'h34011234); cyc();
        check("ori_reg1",  64'(bus.ex_reg1_o),   64'h0);
        check("ori_reg2",  64'(bus.ex_reg2_o),   64'h00001234);
        check("ori_waddr", 64'(bus.ex_waddr_o),  64'd1);
        check("ori_wreg",  64'(bus.ex_wreg_o),   64'd1);
        check("ori_aluop", 64'(bus.ex_aluop_o),  64'h25);
        check("ori_sel",   64'(bus.ex_alusel_o), 64'd1);

        // ADDU $3,$1,$2 with both sources hitting $1: youngest wins
        fwd(2'b11, 5'd1, 32'h55555555, 5'd1, 32'hAAAA0000);
        bus.reg2_data_i = 32'd7;
        instr(32'h104, 32'h00221821); cyc();
        check("addu_reg1", 64'(bus.ex_reg1_o), 64'hAAAA0000);
        check("addu_reg2", 64'(bus.ex_reg2_o), 64'h7);
        check("addu_sel",  64'(bus.ex_alusel_o), 64'd4);

        // LW $4,8($5) then ORI $6,$4,1: one bubble, then forward from fwd[1]
        fwd(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.reg1_data_i = 32'h100;
        instr(32'h108, 32'h8CA40008); cyc();
        check("lw_sel",   64'(bus.ex_alusel_o), 64'd7);
        check("lw_aluop", 64'(bus.ex_aluop_o),  64'hE3);
        check("lw_reg2",  64'(bus.ex_reg2_o),   64'h8);
        instr(32'h10C, 32'h34860001); #1;
        check("lu_stall", 64'(bus.stall_req_o), 64'd1);
        cyc();
        check("lu_bubble", 64'(bus.ex_valid_o), 64'd0);
        check("lu_clear",  64'(bus.stall_req_o), 64'd0);
        fwd(2'b10, 5'd4, 32'hDEAD0000, 5'd0, 32'd0);
        cyc();
        check("lu_reg1", 64'(bus.ex_reg1_o), 64'hDEAD0000);
        check("lu_pc",   64'(bus.ex_pc_o),   64'h10C);

        // ADDIU / LUI with a forwarding source targeting $0
        fwd(2'b01, 5'd0, 32'd0, 5'd0, 32'h12345678);
        instr(32'h110, 32'h2402FFFF); cyc();
        check("addiu_reg2", 64'(bus.ex_reg2_o), 64'hFFFFFFFF);
        check("addiu_reg1", 64'(bus.ex_reg1_o), 64'h0);
        instr(32'h114, 32'h3C028000); #1;
        check("lui_noread", 64'(bus.reg1_read_o), 64'd0);
        cyc();
        check("lui_reg2", 64'(bus.ex_reg2_o), 64'h80000000);
        check("lui_reg1", 64'(bus.ex_reg1_o), 64'h0);

        // XORI latched, then three held cycles, then flush+stall
        fwd(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        bus.reg1_data_i = 32'h0F0F0000;
        instr(32'h200, 32'h38A5F0F0); cyc();
        check("xori_reg2", 64'(bus.ex_reg2_o), 64'h0000F0F0);
        bus.stall_i = 1'b1;
        instr(32'h204, 32'h34011234);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("hold_pc",   64'(bus.ex_pc_o),   64'h200);
            check("hold_reg1", 64'(bus.ex_reg1_o), 64'h0F0F0000);
        end
        bus.flush_i = 1'b1; cyc();
        check("flush_stall", 64'(bus.ex_valid_o), 64'd0);
        bus.flush_i = 1'b0; bus.stall_i = 1'b0;

        // Invalid encodings, then SUBU / NOR
        instr(32'h300, 32'hFC000000); cyc();
        check("inv_flag",  64'(bus.ex_inv_o),   64'd1);
        check("inv_wreg",  64'(bus.ex_wreg_o),  64'd0);
        check("inv_valid", 64'(bus.ex_valid_o), 64'd1);
        instr(32'h304, 32'h00000000); cyc();
        check("zero_inv",  64'(bus.ex_inv_o),   64'd1);
        instr(32'h308, 32'h00223823); cyc();
        check("subu_aluop", 64'(bus.ex_aluop_o), 64'h23);
        instr(32'h30C, 32'h00223827); cyc();
        check("nor_sel",    64'(bus.ex_alusel_o), 64'd1);
        bus.in_valid_i = 1'b0; cyc();
        check("empty_bubble", 64'(bus.ex_valid_o), 64'd0);

`ifdef ID_PERF_CNT_EN
        check("perf_stall", 64'(bus.perf_stall_cnt_o), 64'd1);
        check("perf_inv",   64'(bus.perf_inv_cnt_o),   64'd2);
`else
        check("perf_stall", 64'(bus.perf_stall_cnt_o), 64'd0);
        check("perf_inv",   64'(bus.perf_inv_cnt_o),   64'd0);
`endif

        // Reset with a valid latch, and reset masking a load-use hazard
        instr(32'h400, 32'h34011234); cyc();
        rst = 1'b1; cyc();
        check("rst_mid_valid", 64'(bus.ex_valid_o), 64'd0);
        check("rst_mid_reg2",  64'(bus.ex_reg2_o),  64'd0);
        rst = 1'b0;
        instr(32'h404, 32'h8CA40008); cyc();
        rst = 1'b1;
        instr(32'h408, 32'h34860001); #1;
        check("rst_no_stall", 64'(bus.stall_req_o), 64'd0);
        cyc();
        check("rst_lw_gone", 64'(bus.ex_valid_o), 64'd0);
        rst = 1'b0;
        bus.in_valid_i = 1'b0;
        cyc(); cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Second-generation instruction decode stage for the MIPS-subset pipeline.
- Decodes one instruction per cycle and reads operands through the register-file read ports.
- Resolves RAW hazards through a parametrised number of forwarding sources.
- Detects load-use hazards internally, raises a stall request, and owns the registered ID/EX pipeline latch with stall/flush handling.

Parameters:
- DATA_W, 32, datapath and register width.
- REG_AW, 5, register address width.
- FWD_N, 2, number of forwarding sources; index 0 is youngest (EX), higher indices are older (MEM, WB...).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid_i  in  1  IF/ID holds a valid instruction.
- pc_i  in  DATA_W  instruction address.
- inst_i  in  32  instruction word.
- stall_i  in  1  downstream hold; the ID/EX latch keeps its value.
- flush_i  in  1  replace the next ID/EX contents with a bubble.
- reg1_data_i / reg2_data_i  in  DATA_W  register-file read data (combinational).
- fwd_wreg_i  in  FWD_N  per-source write enable.
- fwd_waddr_i  in  FWD_N*REG_AW  per-source destination; source k at [k*REG_AW +: REG_AW].
- fwd_wdata_i  in  FWD_N*DATA_W  per-source result.
- reg1_read_o / reg2_read_o  out  1  register-file read enables (combinational).
- reg1_addr_o / reg2_addr_o  out  REG_AW  register-file read addresses (combinational).
- stall_req_o  out  1  load-use stall request to IF/ID (combinational).
- ex_valid_o  out  1  ID/EX latch valid.
- ex_pc_o  out  DATA_W  latched PC.
- ex_alusel_o  out  3  latched result select.
- ex_aluop_o  out  8  latched operation.
- ex_reg1_o / ex_reg2_o  out  DATA_W  latched operands.
- ex_waddr_o  out  REG_AW  latched destination.
- ex_wreg_o  out  1  latched write enable.
- ex_inv_o  out  1  latched invalid-instruction flag.

Behaviour:
- Decode, combinational. Fields: op=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0], func=[5:0].
  - ORI 001101 / ANDI 001100 / XORI 001110: reg1=rs, reg2=zero-extended imm, waddr=rt, alusel=001 (LOGIC), aluop 25/24/26.
  - LUI 001111: reg1 not read, reg2={imm,16'b0}, aluop=25, alusel=001, waddr=rt.
  - ADDIU 001001: reg1=rs, reg2=sign-extended imm, alusel=100 (ARITH), aluop=21, waddr=rt.
  - LW 100011: same operands as ADDIU; alusel=111 (LOAD), aluop=E3.
  - SPECIAL 000000, func AND 24 / OR 25 / XOR 26 / NOR 27 / ADDU 21 / SUBU 23: reg1=rs, reg2=rt, waddr=rd, aluop=func. Logic ops use alusel=001; ADDU/SUBU use alusel=100.
  - Any other encoding, including unlisted funcs: inv=1, wreg=0, aluop=00, alusel=000, no reads.
  - An all-zero word decodes as SPECIAL with func 00, so it is flagged invalid.
- Operand select, per port: if read is disabled, the operand is the immediate (port 2) or 0.
  - Read address 0: operand is 0, with no forwarding.
  - Otherwise use the lowest index k where fwd_wreg_i[k] is set and fwd_waddr_i[k] equals the read address; else the register-file data.
- Load-use: stall_req_o=1 when all of the following hold:
  - in_valid_i and ex_valid_o are set, ex_alusel_o=111 and ex_wreg_o=1;
  - ex_waddr_o is non-zero;
  - ex_waddr_o equals an enabled read address.
- Latch update at posedge, in priority order:
  1. rst: bubble.
  2. flush_i: bubble.
  3. stall_i: hold.
  4. stall_req_o: bubble.
  5. !in_valid_i: bubble.
  6. Otherwise load the decoded instruction with valid=1.
- Bubble means all ex_* outputs are 0 (aluop 00 = NOP, alusel 000).
- Latency: one cycle from instruction presentation to ex_* outputs.
- A load-use costs exactly one bubble. On the following cycle the load has left the latch and the value arrives via fwd[k>=1].
- stall_req_o is asserted only while the hazard exists. It is not suppressed by stall_i; upstream holds in both cases.
- flush_i asserted together with stall_i: flush wins.
- Reset mid-operation clears the latch on the next edge. stall_req_o is 0 while rst is set.

Optional Feature:
- ID_PERF_CNT_EN adds ports perf_stall_cnt_o and perf_inv_cnt_o, each 32 bits.
  - perf_stall_cnt_o counts cycles where stall_req_o=1 and stall_i=0.
  - perf_inv_cnt_o counts instructions latched with inv=1.
  - Both counters wrap at 2^32 and clear on rst.
- Without the macro, both ports exist and are tied to 0.

Test Plan:
- ORI $1,$0,0x1234 (34011234), no forwarding: next cycle ex_reg1_o=0, ex_reg2_o=00001234, ex_waddr_o=1, ex_wreg_o=1, aluop=25, alusel=001.
- ADDU $3,$1,$2 with fwd[0]=(1,$1,AAAA0000) and fwd[1]=(1,$1,55555555), reg2_data_i=7: ex_reg1_o=AAAA0000, ex_reg2_o=7.
- LW $4,8($5) latched, followed by ORI $6,$4,1: stall_req_o=1 for one cycle, a bubble is latched, then ORI latched with ex_reg1_o taken from fwd[1].
- ADDIU $2,$0,0xFFFF: ex_reg2_o=FFFFFFFF. LUI $2,0x8000: ex_reg2_o=80000000. Both with fwd_waddr=0 present: operand stays 0.
- stall_i=1 for 3 cycles: ex_* is unchanged. flush_i and stall_i asserted together: bubble. Invalid word FC000000: ex_inv_o=1, ex_wreg_o=0.
- rst asserted with a valid latch: all ex_* are 0 after the edge. With ID_PERF_CNT_EN: one load-use plus two invalid instructions give stall=1 and inv=2.
